// File: rtl/percep_data_loader_if.sv
// Stream-in / write-port bundle between the perceptron data loader and its
// ydx memory and weight register file.
interface percep_data_loader_if #(
    parameter int unsigned MEM_WIDTH_YDX = 17,
    parameter int unsigned MEM_ADDR_YDX  = 7,
    parameter int unsigned MEM_ADDR_WGHT = 3,
    parameter int unsigned FP_WIDTH      = 16
);
    logic                     i_infer_ena;
    logic [MEM_WIDTH_YDX-1:0] i_d_txt_in;
    logic                     o_ydx_we;
    logic [MEM_ADDR_YDX-1:0]  o_ydx_waddr;
    logic [MEM_WIDTH_YDX-1:0] o_ydx_wdata;
    logic                     o_wght_we;
    logic [MEM_ADDR_WGHT-1:0] o_wght_waddr;
    logic [FP_WIDTH-1:0]      o_wght_wdata;
    logic                     o_load_done;
    logic                     o_load_abort;
    logic                     o_wght_err;

    // Loader side
    modport slave (
        input  i_infer_ena, i_d_txt_in,
        output o_ydx_we, o_ydx_waddr, o_ydx_wdata,
        output o_wght_we, o_wght_waddr, o_wght_wdata,
        output o_load_done, o_load_abort, o_wght_err
    );

    // Stream source / observer side
    modport master (
        output i_infer_ena, i_d_txt_in,
        input  o_ydx_we, o_ydx_waddr, o_ydx_wdata,
        input  o_wght_we, o_wght_waddr, o_wght_wdata,
        input  o_load_done, o_load_abort, o_wght_err
    );
endinterface

// File: rtl/percep_data_loader.sv
// Perceptron data loader: routes the serial word stream following infer_ena
// into the ydx memory, then the weight register file, then drops the pad words.
module percep_data_loader #(
    parameter int unsigned MEM_WIDTH_YDX = 17,
    parameter int unsigned MEM_ADDR_YDX  = 7,
    parameter int unsigned MEM_ADDR_WGHT = 3,
    parameter int unsigned INFER_NUM     = 20,
    parameter int unsigned ATTR          = 5,
    parameter int unsigned FP_WIDTH      = 16,
    parameter int unsigned PAD_NUM       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    percep_data_loader_if.slave   bus
);
    localparam int unsigned NYDX     = INFER_NUM * ATTR;
    localparam int unsigned CNT_W    = MEM_ADDR_YDX;
    localparam int unsigned PAD_LAST = (PAD_NUM == 0) ? 0 : PAD_NUM - 1;

    if (NYDX > (2 ** MEM_ADDR_YDX)) begin : g_chk_ydx
        $fatal(1, "percep_data_loader: INFER_NUM*ATTR exceeds ydx address space");
    end
    if (ATTR > (2 ** MEM_ADDR_WGHT)) begin : g_chk_wght
        $fatal(1, "percep_data_loader: ATTR exceeds weight address space");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_YDX  = 3'd1,
        S_LOAD_WGHT = 3'd2,
        S_SKIP      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_ydx_we;
    logic [MEM_ADDR_YDX-1:0]  r_ydx_waddr;
    logic [MEM_WIDTH_YDX-1:0] r_ydx_wdata;
    logic                     r_wght_we;
    logic [MEM_ADDR_WGHT-1:0] r_wght_waddr;
    logic [FP_WIDTH-1:0]      r_wght_wdata;
    logic                     r_load_done;
    logic                     r_load_abort;
    logic                     r_wght_err;

    logic                     w_ena;
    logic [MEM_WIDTH_YDX-1:0] w_word;

    assign w_ena  = bus.i_infer_ena;
    assign w_word = bus.i_d_txt_in;

    // Session FSM; write ports and status flags are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ydx_we     <= 1'b0;
            r_ydx_waddr  <= '0;
            r_ydx_wdata  <= '0;
            r_wght_we    <= 1'b0;
            r_wght_waddr <= '0;
            r_wght_wdata <= '0;
            r_load_done  <= 1'b0;
            r_load_abort <= 1'b0;
            r_wght_err   <= 1'b0;
        end else begin
            r_ydx_we     <= 1'b0;
            r_wght_we    <= 1'b0;
            r_load_abort <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_ena) begin
                        r_state    <= S_LOAD_YDX;
                        r_cnt      <= '0;
                        r_wght_err <= 1'b0;
                    end
                end

                S_LOAD_YDX: begin
                    if (!w_ena) begin
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                        r_load_abort <= 1'b1;
                    end else begin
                        r_ydx_we    <= 1'b1;
                        r_ydx_waddr <= MEM_ADDR_YDX'(r_cnt);
                        r_ydx_wdata <= w_word;
                        if (r_cnt == CNT_W'(NYDX - 1)) begin
                            r_state <= S_LOAD_WGHT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                S_LOAD_WGHT: begin
                    if (!w_ena) begin
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                        r_load_abort <= 1'b1;
                    end else begin
                        r_wght_we    <= 1'b1;
                        r_wght_waddr <= MEM_ADDR_WGHT'(r_cnt);
                        r_wght_wdata <= w_word[FP_WIDTH-1:0];
                        // Tagged word is still written; the flag only reports it
                        if (w_word[MEM_WIDTH_YDX-1]) begin
                            r_wght_err <= 1'b1;
                        end
                        if (r_cnt == CNT_W'(ATTR - 1)) begin
                            r_cnt <= '0;
                            if (PAD_NUM == 0) begin
                                r_state     <= S_DONE;
                                r_load_done <= 1'b1;
                            end else begin
                                r_state <= S_SKIP;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                S_SKIP: begin
                    if (!w_ena) begin
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                        r_load_abort <= 1'b1;
                    end else if (r_cnt == CNT_W'(PAD_LAST)) begin
                        r_state     <= S_DONE;
                        r_cnt       <= '0;
                        r_load_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (!w_ena) begin
                        r_state     <= S_IDLE;
                        r_load_done <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_load_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ydx_we     = r_ydx_we;
    assign bus.o_ydx_waddr  = r_ydx_waddr;
    assign bus.o_ydx_wdata  = r_ydx_wdata;
    assign bus.o_wght_we    = r_wght_we;
    assign bus.o_wght_waddr = r_wght_waddr;
    assign bus.o_wght_wdata = r_wght_wdata;
    assign bus.o_load_done  = r_load_done;
    assign bus.o_load_abort = r_load_abort;
    assign bus.o_wght_err   = r_wght_err;
endmodule

// File: tb/tb_percep_data_loader.sv
// Directed bench for percep_data_loader: normal load, tag error, abort,
// async reset mid-weights and DONE hold.
module tb_percep_data_loader;
    localparam int unsigned MEM_WIDTH_YDX = 17;
    localparam int unsigned MEM_ADDR_YDX  = 7;
    localparam int unsigned MEM_ADDR_WGHT = 3;
    localparam int unsigned FP_WIDTH      = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ydx_wr = 0;
    int   n_wght_wr = 0;
    int   n_both = 0;

    always #5 clk = ~clk;

    percep_data_loader_if #(
        .MEM_WIDTH_YDX(MEM_WIDTH_YDX), .MEM_ADDR_YDX(MEM_ADDR_YDX),
        .MEM_ADDR_WGHT(MEM_ADDR_WGHT), .FP_WIDTH(FP_WIDTH)
    ) bus ();

    percep_data_loader #(
        .MEM_WIDTH_YDX(MEM_WIDTH_YDX), .MEM_ADDR_YDX(MEM_ADDR_YDX),
        .MEM_ADDR_WGHT(MEM_ADDR_WGHT), .INFER_NUM(20), .ATTR(5),
        .FP_WIDTH(FP_WIDTH), .PAD_NUM(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Write-cycle census, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_ydx_we)  n_ydx_wr++;
            if (bus.o_wght_we) n_wght_wr++;
            if (bus.o_ydx_we && bus.o_wght_we) n_both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ydx_we"},     32'(bus.o_ydx_we),     32'd0);
        check({tag, ".ydx_waddr"},  32'(bus.o_ydx_waddr),  32'd0);
        check({tag, ".ydx_wdata"},  32'(bus.o_ydx_wdata),  32'd0);
        check({tag, ".wght_we"},    32'(bus.o_wght_we),    32'd0);
        check({tag, ".wght_waddr"}, 32'(bus.o_wght_waddr), 32'd0);
        check({tag, ".wght_wdata"}, 32'(bus.o_wght_wdata), 32'd0);
        check({tag, ".load_done"},  32'(bus.o_load_done),  32'd0);
        check({tag, ".load_abort"}, 32'(bus.o_load_abort), 32'd0);
        check({tag, ".wght_err"},   32'(bus.o_wght_err),   32'd0);
    endtask

    initial begin
        bus.i_infer_ena = 1'b0;
        bus.i_d_txt_in  = '0;

        // Reset state
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Session 1: normal load, words k+400
        bus.i_infer_ena = 1'b1;
        step();
        check("s1.start_no_write", 32'(bus.o_ydx_we), 32'd0);
        for (int k = 0; k < 108; k++) begin
            bus.i_d_txt_in = 17'(k + 400);
            step();
            if (k < 100) begin
                check("s1.ydx_we",    32'(bus.o_ydx_we),    32'd1);
                check("s1.ydx_waddr", 32'(bus.o_ydx_waddr), 32'(k));
                check("s1.ydx_wdata", 32'(bus.o_ydx_wdata), 32'(k + 400));
                check("s1.ydx_wght_we", 32'(bus.o_wght_we), 32'd0);
            end else if (k < 105) begin
                check("s1.wght_we",    32'(bus.o_wght_we),    32'd1);
                check("s1.wght_waddr", 32'(bus.o_wght_waddr), 32'(k - 100));
                check("s1.wght_wdata", 32'(bus.o_wght_wdata), 32'(k + 400));
                check("s1.wght_ydx_we", 32'(bus.o_ydx_we),    32'd0);
                check("s1.wght_err",   32'(bus.o_wght_err),   32'd0);
                check("s1.wght_done",  32'(bus.o_load_done),  32'd0);
            end else begin
                check("s1.pad_ydx_we",  32'(bus.o_ydx_we),    32'd0);
                check("s1.pad_wght_we", 32'(bus.o_wght_we),   32'd0);
                check("s1.pad_done",    32'(bus.o_load_done), (k == 107) ? 32'd1 : 32'd0);
            end
        end
        check("s1.wght_err_done", 32'(bus.o_wght_err), 32'd0);

        // DONE hold with infer_ena still high
        for (int k = 0; k < 20; k++) begin
            bus.i_d_txt_in = 17'(k + 600);
            step();
            check("hold.done",    32'(bus.o_load_done), 32'd1);
            check("hold.ydx_we",  32'(bus.o_ydx_we),    32'd0);
            check("hold.wght_we", 32'(bus.o_wght_we),   32'd0);
        end
        check("s1.n_ydx_wr",  32'(n_ydx_wr),  32'd100);
        check("s1.n_wght_wr", 32'(n_wght_wr), 32'd5);
        bus.i_infer_ena = 1'b0;
        step();
        check("hold.done_clear", 32'(bus.o_load_done), 32'd0);

        // Session 2: weight w2 carries the tag bit
        bus.i_infer_ena = 1'b1;
        step();
        for (int k = 0; k < 108; k++) begin
            bus.i_d_txt_in = (k == 102) ? 17'h1_3C00 : 17'(k);
            step();
            if (k == 101) check("s2.err_before", 32'(bus.o_wght_err), 32'd0);
            if (k == 102) begin
                check("s2.w2_we",    32'(bus.o_wght_we),    32'd1);
                check("s2.w2_waddr", 32'(bus.o_wght_waddr), 32'd2);
                check("s2.w2_wdata", 32'(bus.o_wght_wdata), 32'h3C00);
                check("s2.err_set",  32'(bus.o_wght_err),   32'd1);
            end
            if (k == 104) check("s2.w4_wdata", 32'(bus.o_wght_wdata), 32'd104);
        end
        check("s2.done",     32'(bus.o_load_done), 32'd1);
        check("s2.err_done", 32'(bus.o_wght_err),  32'd1);
        bus.i_infer_ena = 1'b0;
        step();
        check("s2.err_idle", 32'(bus.o_wght_err), 32'd1);

        // Session 3: abort after ydx word 37
        bus.i_infer_ena = 1'b1;
        step();
        check("s3.err_cleared", 32'(bus.o_wght_err), 32'd0);
        for (int k = 0; k < 38; k++) begin
            bus.i_d_txt_in = 17'(k + 1000);
            step();
        end
        check("s3.last_waddr", 32'(bus.o_ydx_waddr), 32'd37);
        check("s3.last_wdata", 32'(bus.o_ydx_wdata), 32'd1037);
        bus.i_infer_ena = 1'b0;
        bus.i_d_txt_in  = 17'd1038;
        step();
        check("abort.pulse",      32'(bus.o_load_abort), 32'd1);
        check("abort.no_write",   32'(bus.o_ydx_we),     32'd0);
        check("abort.waddr_hold", 32'(bus.o_ydx_waddr),  32'd37);
        check("abort.wdata_hold", 32'(bus.o_ydx_wdata),  32'd1037);
        bus.i_infer_ena = 1'b1;
        step();
        check("abort.pulse_end", 32'(bus.o_load_abort), 32'd0);
        check("rearm.no_write",  32'(bus.o_ydx_we),     32'd0);

        // Session 4: re-armed load, then async reset during weights
        for (int k = 0; k < 102; k++) begin
            bus.i_d_txt_in = 17'(k + 2000);
            step();
            if (k == 0) begin
                check("rearm.we",    32'(bus.o_ydx_we),    32'd1);
                check("rearm.waddr", 32'(bus.o_ydx_waddr), 32'd0);
                check("rearm.wdata", 32'(bus.o_ydx_wdata), 32'd2000);
            end
        end
        check("s4.wght_we",    32'(bus.o_wght_we),    32'd1);
        check("s4.wght_waddr", 32'(bus.o_wght_waddr), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #2;
        rst = 1'b0;
        bus.i_d_txt_in = 17'd77;
        step();
        check("post_rst.no_write", 32'(bus.o_ydx_we), 32'd0);
        bus.i_d_txt_in = 17'h0_1234;
        step();
        check("post_rst.we",    32'(bus.o_ydx_we),    32'd1);
        check("post_rst.waddr", 32'(bus.o_ydx_waddr), 32'd0);
        check("post_rst.wdata", 32'(bus.o_ydx_wdata), 32'h1234);
        bus.i_infer_ena = 1'b0;
        step();
        check("post_rst.abort", 32'(bus.o_load_abort), 32'd1);

        check("excl.both_we", 32'(n_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
